// File: rtl/adder_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl_if
// Request/result bundle for the multi-precision add/subtract sequencer.
//   start    : request, only looked at while the sequencer is idle
//   op       : 0 = add, 1 = subtract (captured with start)
//   a_in     : operand A, BITS*WORDS wide (captured with start)
//   b_in     : operand B, BITS*WORDS wide (captured with start)
//   cin_in   : carry-in for add, ignored for subtract (captured with start)
//   busy     : sequencer is running or presenting its result
//   done     : one-cycle pulse, result is valid
//   sum_out  : result register
//   cout_out : final carry; for subtract 1 means no borrow (A >= B)
// master = requester side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface adder_seq_ctrl_if #(
    parameter int BITS  = 4,
    parameter int WORDS = 4
);
    localparam int W = BITS * WORDS;

    logic         start;
    logic         op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout_out;

    modport master (
        output start, op, a_in, b_in, cin_in,
        input  busy, done, sum_out, cout_out
    );

    modport slave (
        input  start, op, a_in, b_in, cin_in,
        output busy, done, sum_out, cout_out
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl
// Multi-precision add/subtract built from one BITS-wide adder slice that is
// reused WORDS times, least-significant slice first, with the carry held in
// a register between slices.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears control and result state
//   bus   : adder_seq_ctrl_if.slave (start/op/a_in/b_in/cin_in in,
//           busy/done/sum_out/cout_out out)
// Timing: start accepted at edge E0, done is high for the one cycle after
// edge E(WORDS); the next request can be accepted the cycle after done.
// ---------------------------------------------------------------------------
module adder_seq_ctrl #(
    parameter int BITS  = 4,
    parameter int WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_seq_ctrl_if.slave  bus
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state;
    state_t                     state_nxt;

    logic [WORDS-1:0][BITS-1:0] a_r;
    logic [WORDS-1:0][BITS-1:0] b_r;
    logic [WORDS-1:0][BITS-1:0] sum_r;
    logic                       carry_r;
    logic                       cout_r;
    logic [IW-1:0]              idx;

    logic [BITS-1:0]            add_sum;
    logic                       add_cout;
    logic                       last_slice;

    assign last_slice = (idx == LAST);

    adder_n #(.BITS(BITS)) u_add (
        .a    (a_r[idx]),
        .b    (b_r[idx]),
        .cin  (carry_r),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                bus.busy = 1'b1;
                if (last_slice) state_nxt = DONE;
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: B is inverted at capture and the initial
    // carry forced to 1, so the slice loop is identical for both ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_r     <= bus.a_in;
                    b_r     <= bus.op ? ~bus.b_in : bus.b_in;
                    carry_r <= bus.op ? 1'b1 : bus.cin_in;
                    idx     <= '0;
                    sum_r   <= '0;
                    cout_r  <= 1'b0;
                end
                RUN: begin
                    sum_r[idx] <= add_sum;
                    carry_r    <= add_cout;
                    if (last_slice) begin
                        cout_r <= add_cout;
                        idx    <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum_out  = sum_r;
    assign bus.cout_out = cout_r;
endmodule

// Plain BITS-wide ripple adder slice.
module adder_n #(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, cin};
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_seq_ctrl
// Drives three sequencer configurations (4x4, 8x1, 2x2) and compares
// latency, result and handshake against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_adder_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_seq_ctrl_if #(.BITS(4), .WORDS(4)) bus44 ();
    adder_seq_ctrl_if #(.BITS(8), .WORDS(1)) bus81 ();
    adder_seq_ctrl_if #(.BITS(2), .WORDS(2)) bus22 ();

    adder_seq_ctrl #(.BITS(4), .WORDS(4)) dut44 (.clk(clk), .rst_n(rst_n), .bus(bus44.slave));
    adder_seq_ctrl #(.BITS(8), .WORDS(1)) dut81 (.clk(clk), .rst_n(rst_n), .bus(bus81.slave));
    adder_seq_ctrl #(.BITS(2), .WORDS(2)) dut22 (.clk(clk), .rst_n(rst_n), .bus(bus22.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {carry, sum} of a w-bit add or subtract, straight from the arithmetic.
    function automatic logic [63:0] ref_sum(input int w, input bit o,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input bit c);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        if (o) return (a & m) + ((~b) & m) + 64'd1;
        else   return (a & m) + (b & m) + {63'd0, c};
    endfunction

    // Caller is 1 time unit after a rising edge with the DUT idle.
    task automatic go44(input bit o, input logic [15:0] a, input logic [15:0] b,
                        input bit c, input string tag);
        int k;
        bus44.start = 1'b1; bus44.op = o; bus44.a_in = a; bus44.b_in = b; bus44.cin_in = c;
        @(posedge clk); #1;
        bus44.start = 1'b0;
        bus44.a_in  = 16'($urandom);
        bus44.b_in  = 16'($urandom);
        check_val({tag, "_busy"}, 64'(bus44.busy), 64'd1);
        k = 0;
        while (bus44.done !== 1'b1 && k < 20) begin
            if (k > 0) check_val({tag, "_runcout"}, 64'(bus44.cout_out), 64'd0);
            @(posedge clk); #1;
            k++;
        end
        check_val({tag, "_lat"}, 64'(k), 64'd4);
        check_val({tag, "_res"}, 64'({bus44.cout_out, bus44.sum_out}), ref_sum(16, o, 64'(a), 64'(b), c));
        @(posedge clk); #1;
        check_val({tag, "_end"}, 64'({bus44.busy, bus44.done}), 64'd0);
    endtask

    task automatic go81(input bit o, input logic [7:0] a, input logic [7:0] b,
                        input bit c, input string tag);
        int k;
        bus81.start = 1'b1; bus81.op = o; bus81.a_in = a; bus81.b_in = b; bus81.cin_in = c;
        @(posedge clk); #1;
        bus81.start = 1'b0;
        k = 0;
        while (bus81.done !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_val({tag, "_lat"}, 64'(k), 64'd1);
        check_val({tag, "_res"}, 64'({bus81.cout_out, bus81.sum_out}), ref_sum(8, o, 64'(a), 64'(b), c));
        @(posedge clk); #1;
        check_val({tag, "_end"}, 64'({bus81.busy, bus81.done}), 64'd0);
    endtask

    task automatic go22(input bit o, input logic [3:0] a, input logic [3:0] b, input bit c);
        int k;
        bus22.start = 1'b1; bus22.op = o; bus22.a_in = a; bus22.b_in = b; bus22.cin_in = c;
        @(posedge clk); #1;
        bus22.start = 1'b0;
        k = 0;
        while (bus22.done !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_val($sformatf("x22_lat_%0d%0d_%h_%h", o, c, a, b), 64'(k), 64'd2);
        check_val($sformatf("x22_res_%0d%0d_%h_%h", o, c, a, b),
                  64'({bus22.cout_out, bus22.sum_out}), ref_sum(4, o, 64'(a), 64'(b), c));
        @(posedge clk); #1;
        check_val($sformatf("x22_once_%0d%0d_%h_%h", o, c, a, b), 64'(bus22.done), 64'd0);
    endtask

    initial begin
        int k;
        int seen;
        bus44.start = 1'b0; bus44.op = 1'b0; bus44.a_in = '0; bus44.b_in = '0; bus44.cin_in = 1'b0;
        bus81.start = 1'b0; bus81.op = 1'b0; bus81.a_in = '0; bus81.b_in = '0; bus81.cin_in = 1'b0;
        bus22.start = 1'b0; bus22.op = 1'b0; bus22.a_in = '0; bus22.b_in = '0; bus22.cin_in = 1'b0;

        #12;
        check_val("rst_state", 64'({bus44.busy, bus44.done, bus44.cout_out, bus44.sum_out}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("idle_busy", 64'(bus44.busy), 64'd0);

        // Directed 4x4 cases
        go44(1'b0, 16'hFFFF, 16'h0001, 1'b0, "wrap");
        go44(1'b0, 16'h1234, 16'h4321, 1'b1, "add_cin");
        go44(1'b1, 16'h1234, 16'h1235, 1'b0, "sub_borrow");
        go44(1'b1, 16'h8000, 16'h0001, 1'b0, "sub_noborrow");
        check_val("idle_hold", 64'({bus44.cout_out, bus44.sum_out}), 64'h17FFF);

        // start held high, operand changed after acceptance
        bus44.start = 1'b1; bus44.op = 1'b0; bus44.a_in = 16'h00FF; bus44.b_in = 16'h0001; bus44.cin_in = 1'b0;
        @(posedge clk); #1;
        bus44.a_in = 16'hAAAA;
        k = 0;
        while (bus44.done !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("hold_lat", 64'(k), 64'd4);
        check_val("hold_res", 64'({bus44.cout_out, bus44.sum_out}), 64'h00100);
        @(posedge clk); #1;
        check_val("hold_idle", 64'(bus44.busy), 64'd0);
        @(posedge clk); #1;
        check_val("hold_reaccept", 64'(bus44.busy), 64'd1);
        bus44.start = 1'b0;
        k = 0;
        while (bus44.done !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("hold2_lat", 64'(k), 64'd4);
        check_val("hold2_res", 64'({bus44.cout_out, bus44.sum_out}), ref_sum(16, 1'b0, 64'hAAAA, 64'h0001, 1'b0));
        @(posedge clk); #1;

        // Asynchronous reset after two RUN edges
        bus44.start = 1'b1; bus44.op = 1'b0; bus44.a_in = 16'h1111; bus44.b_in = 16'h2222; bus44.cin_in = 1'b0;
        @(posedge clk); #1;
        bus44.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check_val("pre_rst_partial", 64'(bus44.sum_out), 64'h0033);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst", 64'({bus44.busy, bus44.done, bus44.cout_out, bus44.sum_out}), 64'd0);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus44.done === 1'b1 || bus44.busy === 1'b1) seen++;
        end
        check_val("post_rst_quiet", 64'(seen), 64'd0);
        go44(1'b0, 16'h1111, 16'h2222, 1'b0, "post_rst");

        // Randomized 4x4 operations
        for (int i = 0; i < 40; i++)
            go44(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

        // Single-slice configuration
        go81(1'b0, 8'hC8, 8'h64, 1'b0, "w1_dir");
        for (int i = 0; i < 20; i++)
            go81(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("w1_rnd%0d", i));

        // Exhaustive 2x2
        for (int o = 0; o < 2; o++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        go22(1'(o), 4'(a), 4'(b), 1'(c));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-precision add/subtract sequencer. It time-shares one BITS-wide adder_n instance to compute a WORDS*BITS-wide sum, one slice per clock cycle, least-significant slice first. The carry is chained through a register between slices. It sits between a requester using a start/done handshake and the narrow adder datapath, and it instantiates adder_n internally.

Parameters:
BITS, 4, width of the adder_n slice and of each operand word
WORDS, 4, number of slices; total operand width W = BITS*WORDS; legal range WORDS >= 1

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
op  input  1  0 = add, 1 = subtract; sampled with start
a_in  input  W  operand A; sampled with start
b_in  input  W  operand B; sampled with start
cin_in  input  1  carry-in for add; ignored for subtract; sampled with start
busy  output  1  high in RUN and DONE
done  output  1  single-cycle pulse; result valid
sum_out  output  W  result register
cout_out  output  1  final carry; for subtract, 1 = no borrow (A >= B)

Behaviour:
- Reset: rst_n low immediately forces all of the following, regardless of the clock:
  - state = IDLE
  - busy = 0, done = 0
  - sum_out = 0, cout_out = 0
  - slice index = 0, carry register = 0
  - operand registers = 0
- Reset deassertion mid-operation leaves the block in IDLE. The aborted operation is lost and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start = 1 at an edge:
  - latch a_in into A_r, and b_in (op = 0) or ~b_in (op = 1) into B_r
  - carry register = cin_in (op = 0) or 1 (op = 1)
  - index = 0, sum_out = 0, cout_out = 0
  - next state = RUN
- IDLE, start = 0: hold. sum_out and cout_out keep the previous result.
- RUN, each edge:
  - adder_n inputs: a = A_r[idx*BITS +: BITS], b = B_r[idx*BITS +: BITS], cin = carry register
  - commit the adder sum to sum_out[idx*BITS +: BITS]
  - carry register <= adder cout
  - idx <= idx + 1
- RUN, on the edge that commits slice WORDS-1:
  - cout_out <= adder cout
  - done <= 1, next state = DONE
  - idx is not incremented past WORDS-1; it resets to 0
- DONE: lasts exactly one cycle, with done = 1. Next edge: done <= 0, state = IDLE.
- Latency: start is accepted at edge E0. done is high during the cycle following edge E(WORDS). For WORDS = 4, done is high 4 cycles after acceptance.
- Throughput: a new start is accepted at the earliest one cycle after done, i.e. the first IDLE cycle. The minimum period is WORDS+2 cycles.
- start while busy = 1 is ignored entirely: no latch, and no queueing.
- sum_out is only guaranteed correct when done = 1 or afterwards in IDLE. During RUN, upper slices read 0 until they are written.
- cout_out stays 0 during RUN.
- Arithmetic is modulo 2^W. Operands change after acceptance have no effect.
- WORDS = 1: RUN lasts one edge, so done comes 1 cycle after acceptance.
- idx width = max(1, clog2(WORDS)).

Test Plan:
1. BITS=4, WORDS=4: reset, then start with op=0, a=0xFFFF, b=0x0001, cin=0 -> done pulses exactly 4 cycles after acceptance, sum_out=0x0000, cout_out=1, busy deasserts the cycle after done.
2. op=0, a=0x1234, b=0x4321, cin=1 -> sum_out=0x5556, cout_out=0. Then op=1, a=0x1234, b=0x1235 -> sum_out=0xFFFF, cout_out=0. Then op=1, a=0x8000, b=0x0001 -> sum_out=0x7FFF, cout_out=1.
3. Accept start with a=0x00FF, b=0x0001, then hold start=1 and change a=0xAAAA during RUN and DONE -> first result 0x0100, cout_out=0. A second operation starts in the first IDLE cycle using the then-current inputs.
4. Accept start, pull rst_n low asynchronously mid-cycle after 2 RUN edges -> busy, done, sum_out and cout_out read 0 immediately. After release, state is IDLE with no done pulse; a fresh start computes correctly.
5. WORDS=1, BITS=8: a=0xC8, b=0x64 -> done 1 cycle after acceptance, sum_out=0x2C, cout_out=1.
6. Exhaustive check, BITS=2, WORDS=2: all a, b, cin, op combinations -> {cout_out, sum_out} equals a+b+cin (add) or a+~b+1 (subtract), with done exactly once per operation.
